alu_stream: RTL and testbench

- Parametrised, registered successor to the datapath ALU for the downsampling processor.
- Accepts one operation per valid/ready handshake and returns a registered result with Z/C/N flags under a valid/ready handshake.
- Adds an iterative shift-add multiplier as a multi-cycle op and AND/XOR/PASSB ops.
- Sits between the register file / immediate mux and the writeback stage; the control unit stalls on in_ready.

---
 rtl/alu_pkg.sv | 30 +++
 rtl/alu_stream_if.sv | 35 +++
 rtl/alu_mul_iter.sv | 79 +++++++
 rtl/alu_stream.sv | 172 +++++++++++++++++
 tb/tb_alu_stream.sv | 218 +++++++++++++++++++++
 5 files changed

// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the alu_stream slice.
//   - opcode encodings (OP_INCR .. OP_PASSB)
//   - FSM state encoding (ST_IDLE, ST_MUL)
//   - bit positions of Z/C/N inside the packed flag vector
package alu_pkg;

  localparam int OP_W = 4;

  localparam logic [OP_W-1:0] OP_INCR  = 4'b0000;
  localparam logic [OP_W-1:0] OP_ADD   = 4'b0001;
  localparam logic [OP_W-1:0] OP_SUB   = 4'b0010;
  localparam logic [OP_W-1:0] OP_AND   = 4'b0011;
  localparam logic [OP_W-1:0] OP_OR    = 4'b0100;
  localparam logic [OP_W-1:0] OP_XOR   = 4'b0101;
  localparam logic [OP_W-1:0] OP_SHL   = 4'b0110;
  localparam logic [OP_W-1:0] OP_SHR   = 4'b0111;
  localparam logic [OP_W-1:0] OP_MUL   = 4'b1000;
  localparam logic [OP_W-1:0] OP_PASSB = 4'b1001;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_MUL  = 1'b1
  } state_e;

  localparam int FLAG_Z = 0;
  localparam int FLAG_C = 1;
  localparam int FLAG_N = 2;
  localparam int FLAG_W = 3;

endpackage

// File: rtl/alu_stream_if.sv
// alu_stream_if: request/response bundle between the control unit and alu_stream.
//   Request : in_valid, in_ready, alu_op, a_in, b_in
//   Response: out_valid, out_ready, alu_out, z_flag, c_flag, n_flag
//   Status  : busy (multiplier running)
// modport master: the requester (control unit / bench).
// modport slave : the ALU.
interface alu_stream_if #(
  parameter int DATA_W = 19
);
  import alu_pkg::*;

  logic              in_valid;
  logic              in_ready;
  logic [OP_W-1:0]   alu_op;
  logic [DATA_W-1:0] a_in;
  logic [DATA_W-1:0] b_in;
  logic              out_valid;
  logic              out_ready;
  logic [DATA_W-1:0] alu_out;
  logic              z_flag;
  logic              c_flag;
  logic              n_flag;
  logic              busy;

  modport master (
    output in_valid, alu_op, a_in, b_in, out_ready,
    input  in_ready, out_valid, alu_out, z_flag, c_flag, n_flag, busy
  );

  modport slave (
    input  in_valid, alu_op, a_in, b_in, out_ready,
    output in_ready, out_valid, alu_out, z_flag, c_flag, n_flag, busy
  );

endinterface

// File: rtl/alu_mul_iter.sv
// alu_mul_iter: iterative unsigned shift-add multiplier, one partial product per cycle.
//   clk, RST : clock, asynchronous active-high reset (aborts a running product)
//   start    : load a/b and begin; takes effect on the clock edge
//   a, b     : operands, sampled only when start is high
//   done     : high during the cycle whose edge applies the final step
//   prod_lo  : low DATA_W bits of the product, valid while done is high
//   ovf      : any of the high DATA_W product bits nonzero, valid while done is high
module alu_mul_iter #(
  parameter int DATA_W = 19,
  parameter int CNT_W  = 5
) (
  input  logic              clk,
  input  logic              RST,
  input  logic              start,
  input  logic [DATA_W-1:0] a,
  input  logic [DATA_W-1:0] b,
  output logic              done,
  output logic [DATA_W-1:0] prod_lo,
  output logic              ovf
);

  logic                run_q, run_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [2*DATA_W-1:0] acc_q, acc_d;
  logic [2*DATA_W-1:0] mcand_q, mcand_d;
  logic [DATA_W-1:0]   mplier_q, mplier_d;

  logic [2*DATA_W-1:0] acc_step;
  logic                last_step;

  // The product including the current step is exposed combinationally so the
  // parent can capture it on the same edge that retires the last step.
  assign acc_step  = acc_q + (mplier_q[0] ? mcand_q : '0);
  assign last_step = run_q && (cnt_q == CNT_W'(DATA_W - 1));

  assign done    = last_step;
  assign prod_lo = acc_step[DATA_W-1:0];
  assign ovf     = |acc_step[2*DATA_W-1:DATA_W];

  always_comb begin
    run_d    = run_q;
    cnt_d    = cnt_q;
    acc_d    = acc_q;
    mcand_d  = mcand_q;
    mplier_d = mplier_q;
    if (start) begin
      run_d    = 1'b1;
      cnt_d    = '0;
      acc_d    = '0;
      mcand_d  = {{DATA_W{1'b0}}, a};
      mplier_d = b;
    end else if (run_q) begin
      acc_d    = acc_step;
      mcand_d  = mcand_q << 1;
      mplier_d = mplier_q >> 1;
      cnt_d    = cnt_q + 1'b1;
      if (last_step) begin
        run_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      run_q    <= 1'b0;
      cnt_q    <= '0;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
    end else begin
      run_q    <= run_d;
      cnt_q    <= cnt_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
    end
  end

endmodule

// File: rtl/alu_stream.sv
// alu_stream: registered streaming ALU with Z/C/N flags and a multi-cycle multiplier.
//   clk  : clock, rising edge
//   RST  : asynchronous active-high reset
//   bus  : alu_stream_if.slave -- request handshake (in_valid/in_ready, alu_op,
//          a_in, b_in), response handshake (out_valid/out_ready, alu_out, flags), busy
// Single-cycle ops produce their result on the accepting edge; MUL runs DATA_W
// steps in alu_mul_iter and writes its result on the edge of the last step.
// Build option: define ALU_SAT_EN to make INCR/ADD saturate to all-ones on carry
// and SUB saturate to zero on borrow (C still reports the overflow).
module alu_stream
  import alu_pkg::*;
#(
  parameter int DATA_W  = 19,
  parameter int SHAMT_W = 5,
  parameter int CNT_W   = 5
) (
  input  logic        clk,
  input  logic        RST,
  alu_stream_if.slave bus
);

  state_e            state_q, state_d;
  logic [DATA_W-1:0] alu_out_q, alu_out_d;
  logic [FLAG_W-1:0] flags_q, flags_d;
  logic              out_valid_q, out_valid_d;
  logic              busy_q, busy_d;

  logic              accept;
  logic              mul_start;
  logic              mul_done;
  logic [DATA_W-1:0] mul_prod;
  logic              mul_ovf;

  logic [DATA_W-1:0] res;
  logic              res_c;
  logic [DATA_W:0]   inc_w;
  logic [DATA_W:0]   sum_w;
  logic [DATA_W:0]   dif_w;
  logic [31:0]       shamt;
  logic              shift_oob;

  function automatic logic [FLAG_W-1:0] mk_flags(input logic [DATA_W-1:0] r, input logic c);
    logic [FLAG_W-1:0] f;
    f         = '0;
    f[FLAG_Z] = (r == '0);
    f[FLAG_C] = c;
    f[FLAG_N] = r[DATA_W-1];
    return f;
  endfunction

  assign bus.in_ready = (state_q == ST_IDLE) && (!out_valid_q || bus.out_ready);
  assign accept       = bus.in_valid && bus.in_ready;

  // Extra top bit on each arithmetic result carries the carry / borrow.
  assign inc_w     = {1'b0, bus.a_in} + {{DATA_W{1'b0}}, 1'b1};
  assign sum_w     = {1'b0, bus.a_in} + {1'b0, bus.b_in};
  assign dif_w     = {1'b0, bus.a_in} - {1'b0, bus.b_in};
  assign shamt     = 32'(bus.b_in[SHAMT_W-1:0]);
  assign shift_oob = (shamt >= 32'(DATA_W));

  // Single-cycle datapath.
  always_comb begin
    res   = '0;
    res_c = 1'b0;
    case (bus.alu_op)
      OP_INCR: begin
        res_c = inc_w[DATA_W];
`ifdef ALU_SAT_EN
        res = inc_w[DATA_W] ? '1 : inc_w[DATA_W-1:0];
`else
        res = inc_w[DATA_W-1:0];
`endif
      end
      OP_ADD: begin
        res_c = sum_w[DATA_W];
`ifdef ALU_SAT_EN
        res = sum_w[DATA_W] ? '1 : sum_w[DATA_W-1:0];
`else
        res = sum_w[DATA_W-1:0];
`endif
      end
      OP_SUB: begin
        res_c = dif_w[DATA_W];
`ifdef ALU_SAT_EN
        res = dif_w[DATA_W] ? '0 : dif_w[DATA_W-1:0];
`else
        res = dif_w[DATA_W-1:0];
`endif
      end
      OP_AND:   res = bus.a_in & bus.b_in;
      OP_OR:    res = bus.a_in | bus.b_in;
      OP_XOR:   res = bus.a_in ^ bus.b_in;
      OP_SHL:   res = shift_oob ? '0 : (bus.a_in << shamt);
      OP_SHR:   res = shift_oob ? '0 : (bus.a_in >> shamt);
      OP_PASSB: res = bus.b_in;
      default:  ;
    endcase
  end

  alu_mul_iter #(
    .DATA_W (DATA_W),
    .CNT_W  (CNT_W)
  ) u_mul (
    .clk     (clk),
    .RST     (RST),
    .start   (mul_start),
    .a       (bus.a_in),
    .b       (bus.b_in),
    .done    (mul_done),
    .prod_lo (mul_prod),
    .ovf     (mul_ovf)
  );

  always_comb begin
    state_d     = state_q;
    alu_out_d   = alu_out_q;
    flags_d     = flags_q;
    // A consumed result drops out_valid unless a new result lands on this edge.
    out_valid_d = out_valid_q && !bus.out_ready;
    busy_d      = busy_q;
    mul_start   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          if (bus.alu_op == OP_MUL) begin
            state_d   = ST_MUL;
            busy_d    = 1'b1;
            mul_start = 1'b1;
          end else begin
            alu_out_d   = res;
            flags_d     = mk_flags(res, res_c);
            out_valid_d = 1'b1;
          end
        end
      end
      ST_MUL: begin
        if (mul_done) begin
          alu_out_d   = mul_prod;
          flags_d     = mk_flags(mul_prod, mul_ovf);
          out_valid_d = 1'b1;
          busy_d      = 1'b0;
          state_d     = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge RST) begin
    if (RST) begin
      state_q     <= ST_IDLE;
      alu_out_q   <= '0;
      flags_q     <= '0;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      alu_out_q   <= alu_out_d;
      flags_q     <= flags_d;
      out_valid_q <= out_valid_d;
      busy_q      <= busy_d;
    end
  end

  assign bus.alu_out   = alu_out_q;
  assign bus.z_flag    = flags_q[FLAG_Z];
  assign bus.c_flag    = flags_q[FLAG_C];
  assign bus.n_flag    = flags_q[FLAG_N];
  assign bus.out_valid = out_valid_q;
  assign bus.busy      = busy_q;

endmodule

// File: tb/tb_alu_stream.sv
// tb_alu_stream: directed self-checking bench for alu_stream (DATA_W=19).
// Inputs are driven and outputs sampled on the falling clock edge.
module tb_alu_stream;
  import alu_pkg::*;

  localparam int DW = 19;

  logic clk = 1'b0;
  logic RST = 1'b1;
  int   errors = 0;
  int   checks = 0;

  always #5 clk = ~clk;

  alu_stream_if #(.DATA_W(DW)) bus ();

  alu_stream #(
    .DATA_W  (DW),
    .SHAMT_W (5),
    .CNT_W   (5)
  ) dut (
    .clk (clk),
    .RST (RST),
    .bus (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Called on a falling edge; returns on the falling edge after the accepting edge.
  task automatic send(input logic [3:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
    int n;
    n = 0;
    bus.alu_op   = op;
    bus.a_in     = a;
    bus.b_in     = b;
    bus.in_valid = 1'b1;
    while (bus.in_ready !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("accept_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    bus.in_valid = 1'b0;
    // Scramble operands so a design that re-samples them after accept is caught.
    bus.a_in     = ~a;
    bus.b_in     = ~b;
  endtask

  task automatic check_res(input string tag, input logic [DW-1:0] exp_out, input logic [2:0] exp_zcn);
    $display("txn %s: out=%h z=%b c=%b n=%b valid=%b", tag, bus.alu_out,
             bus.z_flag, bus.c_flag, bus.n_flag, bus.out_valid);
    chk({tag, "_valid"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_out"}, 32'(bus.alu_out), 32'(exp_out));
    chk({tag, "_zcn"}, 32'({bus.z_flag, bus.c_flag, bus.n_flag}), 32'(exp_zcn));
  endtask

  // Waits for a MUL result and checks the accept-to-valid latency (counted in cycles,
  // the accepting cycle being cycle 1). Also exercises in_valid while busy.
  task automatic wait_mul(input string tag);
    int lat;
    lat = 1;
    while (bus.out_valid !== 1'b1 && lat < 100) begin
      if (lat == 3) begin
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        bus.alu_op   = OP_PASSB;
        bus.b_in     = 19'h00001;
        bus.in_valid = 1'b1;
      end
      if (lat == 5) chk({tag, "_in_ready_busy"}, 32'(bus.in_ready), 32'd0);
      if (lat == 10) bus.in_valid = 1'b0;
      @(negedge clk);
      lat++;
    end
    chk({tag, "_latency"}, 32'(lat), 32'd20);
    chk({tag, "_busy_done"}, 32'(bus.busy), 32'd0);
  endtask

  initial begin
    int seen;
    logic [DW-1:0] held;
    logic [2:0]    held_f;

    bus.in_valid  = 1'b0;
    bus.alu_op    = '0;
    bus.a_in      = '0;
    bus.b_in      = '0;
    bus.out_ready = 1'b1;

    repeat (3) @(negedge clk);
    RST = 1'b0;
    @(negedge clk);
    chk("rst_out", 32'(bus.alu_out), 32'd0);
    chk("rst_flags", 32'({bus.z_flag, bus.c_flag, bus.n_flag}), 32'd0);
    chk("rst_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_busy", 32'(bus.busy), 32'd0);
    chk("rst_in_ready", 32'(bus.in_ready), 32'd1);

    // Arithmetic and logic.
    send(OP_ADD, 19'h7FFFF, 19'h00001);
`ifdef ALU_SAT_EN
    check_res("add_carry", 19'h7FFFF, 3'b011);
`else
    check_res("add_carry", 19'h00000, 3'b110);
`endif
    send(OP_ADD, 19'h01234, 19'h000FF);
    check_res("add_plain", 19'h01333, 3'b000);
    send(OP_SUB, 19'd5, 19'd7);
`ifdef ALU_SAT_EN
    check_res("sub_borrow", 19'h00000, 3'b110);
`else
    check_res("sub_borrow", 19'h7FFFE, 3'b011);
`endif
    send(OP_SUB, 19'd7, 19'd7);
    check_res("sub_equal", 19'h00000, 3'b100);
    send(OP_INCR, 19'h12345, 19'h00000);
    check_res("incr", 19'h12346, 3'b000);
    send(OP_AND, 19'h5A5A5, 19'h0FF0F);
    check_res("and", 19'h0A505, 3'b000);
    send(OP_XOR, 19'h12345, 19'h54321);
    check_res("xor", 19'h46064, 3'b001);
    send(OP_XOR, 19'h7FFFF, 19'h7FFFF);
    check_res("xor_zero", 19'h00000, 3'b100);
    send(OP_PASSB, 19'h11111, 19'h40001);
    check_res("passb", 19'h40001, 3'b001);
    send(4'b1011, 19'd5, 19'd7);
    check_res("undef_op", 19'h00000, 3'b100);

    // Shifts, including out-of-range amounts.
    send(OP_SHL, 19'd1, 19'd18);
    check_res("shl_18", 19'h40000, 3'b001);
    send(OP_SHL, 19'd1, 19'd19);
    check_res("shl_19", 19'h00000, 3'b100);
    send(OP_SHR, 19'h40000, 19'd31);
    check_res("shr_31", 19'h00000, 3'b100);
    send(OP_SHR, 19'h40000, 19'd4);
    check_res("shr_4", 19'h04000, 3'b000);

    // Back-to-back single-cycle ops with out_ready held high.
    bus.alu_op = OP_INCR; bus.a_in = 19'd1; bus.b_in = 19'd0; bus.in_valid = 1'b1;
    @(posedge clk); @(negedge clk);
    chk("b2b_in_ready", 32'(bus.in_ready), 32'd1);
    check_res("b2b_first", 19'd2, 3'b000);
    bus.alu_op = OP_ADD; bus.a_in = 19'd3; bus.b_in = 19'd4;
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check_res("b2b_second", 19'd7, 3'b000);
    @(negedge clk);
    chk("b2b_drained", 32'(bus.out_valid), 32'd0);

    // Multiplier.
    send(OP_MUL, 19'd300, 19'd200);
    wait_mul("mul_60000");
    check_res("mul_60000", 19'd60000, 3'b000);
    send(OP_MUL, 19'h40000, 19'd2);
    wait_mul("mul_ovf");
    check_res("mul_ovf", 19'h00000, 3'b110);
    send(OP_MUL, 19'h003FF, 19'h00200);
    wait_mul("mul_neg");
    check_res("mul_neg", 19'h7FE00, 3'b001);
    @(negedge clk);

    // Backpressure: result held while out_ready is low.
    bus.out_ready = 1'b0;
    send(OP_OR, 19'h00F00, 19'h30003);
    check_res("or_bp", 19'h30F03, 3'b000);
    held   = bus.alu_out;
    held_f = {bus.z_flag, bus.c_flag, bus.n_flag};
    bus.alu_op = OP_XOR; bus.a_in = 19'h00FF0; bus.b_in = 19'h00F0F; bus.in_valid = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      chk("bp_hold_out", 32'(bus.alu_out), 32'(held));
      chk("bp_hold_flags", 32'({bus.z_flag, bus.c_flag, bus.n_flag}), 32'(held_f));
      chk("bp_in_ready", 32'(bus.in_ready), 32'd0);
      chk("bp_valid", 32'(bus.out_valid), 32'd1);
    end
    bus.out_ready = 1'b1;
    #1;
    chk("bp_release_in_ready", 32'(bus.in_ready), 32'd1);
    @(posedge clk); @(negedge clk);
    bus.in_valid = 1'b0;
    check_res("bp_next_xor", 19'h000FF, 3'b000);
    @(negedge clk);

    // Reset in the middle of a multiply aborts it.
    send(OP_MUL, 19'd300, 19'd200);
    repeat (5) @(negedge clk);
    RST = 1'b1;
    #1;
    chk("rst_mid_busy", 32'(bus.busy), 32'd0);
    @(posedge clk); @(negedge clk);
    chk("rst_mid_out", 32'(bus.alu_out), 32'd0);
    chk("rst_mid_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_mid_flags", 32'({bus.z_flag, bus.c_flag, bus.n_flag}), 32'd0);
    chk("rst_mid_in_ready", 32'(bus.in_ready), 32'd1);
    RST = 1'b0;
    seen = 0;
    for (int i = 0; i < 25; i++) begin
      @(negedge clk);
      if (bus.out_valid === 1'b1) seen++;
    end
    chk("rst_abort_no_result", 32'(seen), 32'd0);

    send(OP_PASSB, 19'd0, 19'h2AAAA);
    check_res("post_rst_passb", 19'h2AAAA, 3'b000);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
